// File: rtl/latch_wr_pkg.sv
// Shared types and default timing for the latch write sequencer.
// The LATCH_WR_VERIFY_EN build makes the VERIFY state reachable.
package latch_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    VERIFY
  } state_t;

  localparam int LW_SETUP_DEF = 1;
  localparam int LW_PULSE_DEF = 2;
  localparam int LW_HOLD_DEF  = 1;

  function automatic int lw_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_wr_timer.sv
// Loadable down-counter shared by the setup, pulse and hold windows.
// expired is high during the last cycle of a loaded window.
module latch_wr_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/latch_write_sequencer.sv
// Drives the gated D-latch bank: present D, setup, enable pulse, hold.
// Define LATCH_WR_VERIFY_EN to add a Q readback cycle that flags failed writes on err.
module latch_write_sequencer
  import latch_wr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = LW_SETUP_DEF,
  parameter int PULSE_CYC = LW_PULSE_DEF,
  parameter int HOLD_CYC  = LW_HOLD_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  input  logic [WIDTH-1:0] lat_q,
  output logic             done,
  output logic             err
);

  localparam int TW = $clog2(lw_max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  if (WIDTH < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
    $error("latch_write_sequencer: WIDTH and all cycle counts must be >= 1");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] lat_d_next;
  logic             lat_en_next;
  logic             in_ready_next;
  logic             done_next;
  logic             err_next;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expired;

  latch_wr_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

`ifndef LATCH_WR_VERIFY_EN
  logic unused_lat_q;
  assign unused_lat_q = ^lat_q;
`endif

  // Every port is a register; the comb block computes their next values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      lat_d    <= '0;
      lat_en   <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      lat_d    <= lat_d_next;
      lat_en   <= lat_en_next;
      in_ready <= in_ready_next;
      done     <= done_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    lat_d_next    = lat_d;
    lat_en_next   = 1'b0;
    in_ready_next = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    case (state)
      IDLE: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready) begin
          lat_d_next    = in_data;
          tmr_load      = 1'b1;
          tmr_val       = TW'(SETUP_CYC);
          state_next    = SETUP;
          in_ready_next = 1'b0;
        end
      end
      SETUP: begin
        if (tmr_expired) begin
          tmr_load    = 1'b1;
          tmr_val     = TW'(PULSE_CYC);
          lat_en_next = 1'b1;
          state_next  = PULSE;
        end
      end
      PULSE: begin
        lat_en_next = 1'b1;
        if (tmr_expired) begin
          tmr_load    = 1'b1;
          tmr_val     = TW'(HOLD_CYC);
          lat_en_next = 1'b0;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (tmr_expired) begin
`ifdef LATCH_WR_VERIFY_EN
          state_next    = VERIFY;
`else
          state_next    = IDLE;
          done_next     = 1'b1;
          in_ready_next = 1'b1;
`endif
        end
      end
`ifdef LATCH_WR_VERIFY_EN
      VERIFY: begin
        // Latch has been closed for HOLD_CYC cycles, so Q is settled here.
        state_next    = IDLE;
        done_next     = 1'b1;
        err_next      = (lat_q != lat_d);
        in_ready_next = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Upstream driver for the gated D-latch bank: accepts a data word over a valid/ready handshake and generates a clean latch write. Each write presents D, waits a setup window, pulses the latch enable for a fixed width, then holds D stable before releasing. Sits between the register/CPU-side logic and the latch bank's `D`/gate inputs. Optionally reads back the latch `Q` outputs to flag write failures.

## Interface
- `WIDTH`, 8, latch bank data width (≥1)
- `SETUP_CYC`, 1, cycles D is stable before enable rises (≥1)
- `PULSE_CYC`, 2, cycles enable is high (≥1)
- `HOLD_CYC`, 1, cycles D is stable after enable falls (≥1)

- `clk`  in  1  system clock; all state updates on its rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  write request
- `in_ready`  out  1  sequencer can accept a request
- `in_data`  in  WIDTH  word to write
- `lat_d`  out  WIDTH  drives latch D inputs
- `lat_en`  out  1  drives latch gate (the latch's `clk` pin)
- `lat_q`  in  WIDTH  latch Q readback (used only with verify)
- `done`  out  1  one-cycle pulse, write complete
- `err`  out  1  one-cycle pulse with `done` on readback mismatch

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, VERIFY (VERIFY exists only with the macro).
- IDLE: `in_ready`=1, `lat_en`=0. Accept when `in_valid && in_ready` at a rising edge; `lat_d` <= `in_data`, load timer with SETUP_CYC, go SETUP.
- SETUP: `lat_en`=0; when the timer expires, load PULSE_CYC, go PULSE.
- PULSE: `lat_en`=1; when the timer expires, load HOLD_CYC, go HOLD.
- HOLD: `lat_en`=0; on expiry, go VERIFY (macro) or IDLE.
- VERIFY: one cycle; sample `lat_q`, compare to `lat_d`; go IDLE.
- `done` is registered and high for exactly the first IDLE cycle after a completed write; `err` is likewise registered and coincident with it.
- `lat_d` changes only on acceptance; it holds the last written word while in IDLE.
- All outputs are registered, and `lat_en` is glitch-free.
- Timer: down-counter, width $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). Parameters of 0 are an elaboration error.

## Timing
- Reset values (while `reset_n`=0 at an edge): state IDLE, `in_ready`=0 during reset (1 from the first cycle after release), `lat_d`=0, `lat_en`=0, `done`=0, `err`=0.
- With acceptance at edge k:
  - `lat_d` is valid from k.
  - `lat_en` is high from edge k+SETUP_CYC to edge k+SETUP_CYC+PULSE_CYC.
  - `done` is high for the cycle after edge k+SETUP_CYC+PULSE_CYC+HOLD_CYC (+1 with verify).
- Busy (`in_ready`=0) for SETUP_CYC+PULSE_CYC+HOLD_CYC(+1) cycles.
- Back-to-back writes: a request is accepted in the `done` cycle, so throughput is one write per busy+1 cycles.
- While busy, `in_valid` is ignored. The requester must hold `in_valid`/`in_data` until accepted.
- Reset mid-write: at the next edge, `lat_en` drops and the state returns to IDLE. No `done` or `err` is produced for the aborted write.
- `lat_q` is sampled only in VERIFY; its value in other states is don't-care.

## Configuration
- Macro `LATCH_WR_VERIFY_EN`.
- Defined: the VERIFY state is present, and `err` pulses with `done` when the sampled `lat_q` != `lat_d`.
- Undefined: no VERIFY state and latency is one cycle shorter; `err` is tied to 0 and `lat_q` is unused.

## Structure
- Package `latch_wr_pkg` holds:
  - the `state_t` enum (IDLE, SETUP, PULSE, HOLD, VERIFY);
  - default timing constants `LW_SETUP_DEF`=1, `LW_PULSE_DEF`=2, `LW_HOLD_DEF`=1.
- Sub-module `latch_wr_timer`: loadable down-counter with a `load`, a `load_val` and an `expired` flag, reused for all three windows.
- The top level contains the FSM, the `lat_d` register, `done`/`err` generation and the handshake.

## Test plan
- Reset then idle:
  - Hold `reset_n`=0 for 3 cycles, then release. Required: `lat_en`=0, `lat_d`=0 and `in_ready`=0 during reset, and `in_ready`=1 on the first post-reset cycle.
- Single write with defaults, `in_data`=0xA5 accepted at edge k:
  - `lat_d`=0xA5 from k.
  - `lat_en` high exactly in cycles k+1..k+2.
  - `done` in cycle k+4 (k+5 with verify).
  - `lat_q`=0xA5 at the latch bank.
- Back-to-back 0x3C then 0xC3 with `in_valid` held: the second write is accepted in the first write's `done` cycle, and `lat_en` gets two separate pulses with at least SETUP_CYC+HOLD_CYC low cycles between them.
- Busy ignore: change `in_data` to 0xFF mid-PULSE while `in_valid`=1. Required: `lat_d` stays at the first word, and 0xFF is written only after `done`.
- Reset mid-PULSE: `lat_en` is 0 after the next edge, with no `done` and no `err`.
- Verify (macro on): force `lat_q`=0x00 for a write of 0x5A. Required: `err`=1 and `done`=1 in the same cycle. An unforced write gives `err`=0.
